// File: rtl/shared_pkg.sv
// Shared types and default sizing for the FIFO write-side blocks.
package shared_pkg;

   typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_FIFO_WIDTH = 16;
   localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin selector: first asserted req searching upward
// from ptr+1, wrapping modulo NUM_REQ.
module fifo_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               valid,
   output logic [ID_W-1:0]    winner_id
);

   logic [2*NUM_REQ-1:0] rot;
   logic [ID_W:0]        off;
   logic [ID_W:0]        sum;

   // Rotating the doubled vector puts candidate ptr+1 at bit 0.
   assign rot = {req, req} >> ({1'b0, ptr} + (ID_W+1)'(1));

   always_comb begin
      off = '0;
      for (int j = NUM_REQ-1; j >= 0; j--) begin
         if (rot[j]) off = (ID_W+1)'(j);
      end
      sum = {1'b0, ptr} + (ID_W+1)'(1) + off;
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
   end

   assign valid     = |req;
   assign winner_id = sum[ID_W-1:0];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers;
// honours fifo_full combinationally so no write is issued while full.
module fifo_wr_arbiter
   import shared_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
   parameter int MAX_BURST  = DEF_MAX_BURST,
   localparam int ID_W      = $clog2(NUM_REQ),
   localparam int CNT_W     = $clog2(MAX_BURST)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   input  logic                          fifo_full,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          fifo_wr_en,
   output logic [FIFO_WIDTH-1:0]         fifo_data_in,
   output logic                          busy,
   output logic [ID_W-1:0]               owner_id,
   output logic [CNT_W-1:0]              burst_cnt
);

   arb_state_e                            state;
   logic [ID_W-1:0]                       ptr;
   logic                                  pick_valid;
   logic [ID_W-1:0]                       pick_id;
   logic [NUM_REQ-1:0][FIFO_WIDTH-1:0]    data_arr;

   fifo_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req       (req),
      .ptr       (ptr),
      .valid     (pick_valid),
      .winner_id (pick_id)
   );

   assign data_arr     = req_data;
   assign fifo_data_in = data_arr[owner_id];
   assign busy         = (state == ARB_BURST);

   always_comb begin
      gnt = '0;
      if (state == ARB_BURST) gnt[owner_id] = req[owner_id] & ~fifo_full;
   end

   assign fifo_wr_en = |gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         ptr       <= ID_W'(NUM_REQ-1);
         owner_id  <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_valid) begin
                  state     <= ARB_BURST;
                  owner_id  <= pick_id;
                  burst_cnt <= '0;
               end
            end
            ARB_BURST: begin
               // Early release ends the burst without taking a beat.
               if (!req[owner_id]) begin
                  state     <= ARB_IDLE;
                  ptr       <= owner_id;
                  burst_cnt <= '0;
               end else if (!fifo_full) begin
                  if (burst_cnt == CNT_W'(MAX_BURST-1)) begin
                     state     <= ARB_IDLE;
                     ptr       <= owner_id;
                     burst_cnt <= '0;
                  end else begin
                     burst_cnt <= burst_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed plus randomized checks of fifo_wr_arbiter against a behavioural
// round-robin burst model.
module tb_fifo_wr_arbiter;

   localparam int N     = 4;
   localparam int W     = 16;
   localparam int MB    = 4;
   localparam int ID_W  = 2;
   localparam int CNT_W = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         req;
   logic [N-1:0][W-1:0]  rdata;
   logic                 fifo_full;
   logic [N-1:0]         gnt;
   logic                 fifo_wr_en;
   logic [W-1:0]         fifo_data_in;
   logic                 busy;
   logic [ID_W-1:0]      owner_id;
   logic [CNT_W-1:0]     burst_cnt;

   fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (rdata),
      .fifo_full    (fifo_full),
      .gnt          (gnt),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_data_in (fifo_data_in),
      .busy         (busy),
      .owner_id     (owner_id),
      .burst_cnt    (burst_cnt)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   bit m_busy;
   int m_owner, m_cnt, m_last;
   logic [N-1:0] last_gnt;
   bit hold_data;
   int wr_seen;
   bit prev_busy;
   int owners[$];

   task automatic model_update();
      bit found;
      if (rst) begin
         m_busy = 0; m_owner = 0; m_cnt = 0; m_last = N-1;
      end else if (!m_busy) begin
         if (req != '0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (m_last + k) % N;
               if (!found && req[c]) begin m_owner = c; found = 1; end
            end
            m_busy = 1; m_cnt = 0;
         end
      end else if (!req[m_owner]) begin
         m_busy = 0; m_last = m_owner; m_cnt = 0;
      end else if (!fifo_full) begin
         m_cnt++;
         if (m_cnt == MB) begin m_busy = 0; m_last = m_owner; m_cnt = 0; end
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] eg;
      eg = '0;
      if (m_busy && req[m_owner] && !fifo_full) eg[m_owner] = 1'b1;
      last_gnt = eg;
      vectors++;
      assert (gnt === eg) else begin
         miscompares++; $error("FAIL gnt: got %b expected %b", gnt, eg);
      end
      assert (fifo_wr_en === (eg != '0)) else begin
         miscompares++; $error("FAIL wr_en: got %b expected %b", fifo_wr_en, eg != '0);
      end
      assert (fifo_data_in === rdata[m_owner]) else begin
         miscompares++; $error("FAIL data: got %h expected %h", fifo_data_in, rdata[m_owner]);
      end
      assert (busy === m_busy) else begin
         miscompares++; $error("FAIL busy: got %b expected %b", busy, m_busy);
      end
      assert (owner_id === ID_W'(m_owner)) else begin
         miscompares++; $error("FAIL owner_id: got %0d expected %0d", owner_id, m_owner);
      end
      assert (burst_cnt === CNT_W'(m_cnt)) else begin
         miscompares++; $error("FAIL burst_cnt: got %0d expected %0d", burst_cnt, m_cnt);
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_outputs();
      if (fifo_wr_en === 1'b1) wr_seen++;
      if (busy === 1'b1 && !prev_busy) owners.push_back(int'(owner_id));
      prev_busy = (busy === 1'b1);
      @(posedge clk);
      #1;
      model_update();
      for (int i = 0; i < N; i++)
         if (last_gnt[i] && !hold_data) rdata[i] = W'($urandom);
   endtask

   task automatic wait_for(input int o, input int c, input string tag);
      int n;
      n = 0;
      while (!(m_busy && m_owner == o && m_cnt == c) && n < 60) begin step(); n++; end
      vectors++;
      assert (m_busy && m_owner == o && m_cnt == c) else begin
         miscompares++;
         $error("FAIL %s: not reached after %0d cycles, expected owner %0d cnt %0d", tag, n, o, c);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (m_busy && n < 60) begin step(); n++; end
      vectors++;
      assert (!m_busy) else begin
         miscompares++; $error("FAIL %s: burst did not end within %0d cycles", tag, n);
      end
   endtask

   task automatic expect_regs(input string tag, input logic eb, input int eo, input int ec);
      vectors++;
      assert (busy === eb && owner_id === ID_W'(eo) && burst_cnt === CNT_W'(ec)) else begin
         miscompares++;
         $error("FAIL %s: got busy=%b owner=%0d cnt=%0d expected busy=%b owner=%0d cnt=%0d",
                tag, busy, owner_id, burst_cnt, eb, eo, ec);
      end
   endtask

   initial begin
      int exp_order[5];
      exp_order = '{0, 1, 2, 3, 0};
      hold_data = 0; prev_busy = 0; wr_seen = 0; last_gnt = '0;
      for (int i = 0; i < N; i++) rdata[i] = W'($urandom);

      // 1: reset with every requester asserted
      rst = 1'b1; req = '1; fifo_full = 1'b0;
      @(posedge clk); #1; model_update();
      step(); step();

      // 2: lone requester 2 with constant data
      rst = 1'b0; req = 4'b0100; hold_data = 1; rdata[2] = 16'hA5A5;
      wr_seen = 0;
      for (int i = 0; i < 15; i++) step();
      vectors++;
      assert (wr_seen == 12) else begin
         miscompares++; $error("FAIL single_req_writes: got %0d expected 12", wr_seen);
      end
      hold_data = 0;

      // 3: round-robin order with all requesting
      rst = 1'b1; req = '1; step();
      rst = 1'b0; owners.delete(); prev_busy = 0;
      for (int i = 0; i < 25; i++) step();
      vectors++;
      assert (owners.size() >= 5) else begin
         miscompares++; $error("FAIL rr_bursts: got %0d bursts expected 5", owners.size());
      end
      for (int i = 0; i < 5 && i < owners.size(); i++) begin
         vectors++;
         assert (owners[i] == exp_order[i]) else begin
            miscompares++; $error("FAIL rr_order[%0d]: got %0d expected %0d", i, owners[i], exp_order[i]);
         end
      end

      // 4: backpressure in owner 1's burst after two beats
      wait_for(1, 2, "bp_reach");
      fifo_full = 1'b1;
      step(); step(); step();
      expect_regs("bp_hold", 1'b1, 1, 2);
      fifo_full = 1'b0; wr_seen = 0;
      wait_idle("bp_drain");
      vectors++;
      assert (wr_seen == 2) else begin
         miscompares++; $error("FAIL bp_remaining: got %0d expected 2", wr_seen);
      end

      // 5: owner 3 releases early, arbitration wraps to 0
      wait_for(3, 1, "early_reach");
      req = 4'b0101;
      step();
      expect_regs("early_idle", 1'b0, 3, 0);
      step();
      expect_regs("wrap_owner0", 1'b1, 0, 0);

      // 6: reset during owner 2's second beat
      wait_for(2, 1, "rst_reach");
      rst = 1'b1;
      step();
      rst = 1'b0;
      expect_regs("rst_regs", 1'b0, 0, 0);
      vectors++;
      assert (gnt === '0 && fifo_wr_en === 1'b0 && fifo_data_in === rdata[0]) else begin
         miscompares++; $error("FAIL rst_outs: got gnt=%b wr=%b data=%h expected 0/0/%h",
                               gnt, fifo_wr_en, fifo_data_in, rdata[0]);
      end
      step();
      expect_regs("post_rst_owner", 1'b1, 0, 0);

      // 7: randomized requests and backpressure
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(7) == 0) req[i] = ~req[i];
         fifo_full = ($urandom_range(3) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the synchronous FIFO among `NUM_REQ` producers. Each producer wins bursts of up to `MAX_BURST` beats. The arbiter drives the FIFO's `wr_en`/`data_in` directly and honours `full` as backpressure, so the FIFO never sees a write while full. It sits between the producer blocks and the FIFO, in the same environment that uses `shared_pkg`.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2)
- `FIFO_WIDTH`, 16, data width; matches FIFO `data_in`
- `MAX_BURST`, 4, maximum beats per grant (≥2)

Derived widths:
- `ID_W` = $clog2(NUM_REQ)
- `CNT_W` = $clog2(MAX_BURST)

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NUM_REQ  per-requester "beat pending"; held with data until granted
- `req_data`  in  NUM_REQ*FIFO_WIDTH  flattened; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- `fifo_full`  in  1  FIFO full flag
- `gnt`  out  NUM_REQ  one-hot; beat of requester i accepted this cycle
- `fifo_wr_en`  out  1  FIFO write enable
- `fifo_data_in`  out  FIFO_WIDTH  FIFO write data
- `busy`  out  1  a burst is owned (state BURST)
- `owner_id`  out  ID_W  current or last burst owner
- `burst_cnt`  out  CNT_W  beats accepted in the current burst

## Operation
- FSM states: `ARB_IDLE`, `ARB_BURST`.
- **ARB_IDLE**
  - No grant is issued.
  - If `|req`, pick the first asserted requester searching from `ptr+1` upward modulo NUM_REQ.
  - Next cycle: `owner_id` = winner, `burst_cnt` = 0, state `ARB_BURST`.
- **ARB_BURST**
  - `gnt[owner_id]` = `req[owner_id]` & ~`fifo_full` (combinational); all other `gnt` bits are 0.
  - `fifo_wr_en` = |`gnt`.
  - `fifo_data_in` = `req_data` slice of `owner_id`. It is muxed continuously, so it is valid whenever `fifo_wr_en` is 1.
  - On an accepted beat with `burst_cnt` < MAX_BURST-1: `burst_cnt`++ and stay.
  - On an accepted beat with `burst_cnt` == MAX_BURST-1: go to `ARB_IDLE`, `ptr` <= `owner_id`, `burst_cnt` <= 0.
  - `req[owner_id]` == 0 (requester released early): go to `ARB_IDLE`, `ptr` <= `owner_id`, `burst_cnt` <= 0. No beat is taken.
  - `fifo_full` = 1 with `req[owner_id]` = 1: stall. State, `burst_cnt` and `owner_id` hold; there is no timeout.
- Requests from non-owners are ignored until re-arbitration. There is no pre-emption.
- Changes to `req` of other requesters during a burst have no effect.
- **Reset:** `state`=`ARB_IDLE`, `ptr`=NUM_REQ-1 (requester 0 searched first), `owner_id`=0, `burst_cnt`=0.
  - Reset therefore forces `gnt`=0, `fifo_wr_en`=0, `busy`=0.
  - `fifo_data_in` shows the requester-0 slice.

## Timing
- Grant-to-write latency is 0 cycles: `fifo_wr_en` rises in the same cycle as `gnt`. The FIFO samples on the same posedge that the requester sees `gnt`.
- Requester rule: keep `req`/data stable until the cycle `gnt[i]`=1. After that posedge, present the next beat or drop `req`.
- Arbitration costs one bubble cycle (`ARB_IDLE`) between bursts. Steady-state throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- `fifo_full` is used combinationally in the same cycle. It must be the registered FIFO flag, so there is no combinational loop through `fifo_wr_en`.
- `rst` asserted mid-burst: takes effect at the next posedge, and any beat whose `gnt` was high in that cycle is still written by the FIFO.
- `busy`, `owner_id`, `burst_cnt` are registered. `gnt`, `fifo_wr_en`, `fifo_data_in` are combinational from registers plus `req`/`fifo_full`/`req_data`.

## Structure
- `shared_pkg` contains:
  - the `typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e`
  - default constants for `NUM_REQ`, `FIFO_WIDTH`, `MAX_BURST`
- Sub-module `fifo_rr_pick`: combinational round-robin selector.
  - Inputs `req`, `ptr`; outputs `valid`, `winner_id`.
  - Parameterised on `NUM_REQ`.
- The top module holds the FSM, the counter, `ptr`, and the data mux.

## Test plan
Configuration: NUM_REQ=4, MAX_BURST=4, FIFO_WIDTH=16, connected to the sync FIFO with the scoreboard checking FIFO contents.
1. **Reset:** hold `rst`=1 for 2 cycles with all `req`=1 -> `gnt`=0, `fifo_wr_en`=0, `busy`=0, `owner_id`=0, `burst_cnt`=0 throughout.
2. **Single requester:** only `req[2]`=1 continuously with `req_data` slice 2 = 16'hA5A5, `fifo_full`=0 -> pattern of 1 idle cycle then 4 consecutive `gnt`=4'b0100 writes of A5A5, repeating (4 writes per 5 cycles).
3. **Round-robin order:** all `req`=1 from reset -> bursts owned 0,1,2,3,0, each exactly 4 beats, separated by 1 idle cycle.
4. **Backpressure:** during owner 1's burst, force `fifo_full`=1 after 2 beats for 3 cycles -> `gnt`=0, `fifo_wr_en`=0, `burst_cnt`=2 held. After release, exactly 2 more beats are written, then the FSM re-arbitrates.
5. **Early release and wrap:** owner 3 drops `req[3]` after 1 beat while `req[0]` and `req[2]`=1 -> `ARB_IDLE` next cycle, next owner 0 (wrap-around past 3), `burst_cnt` restarts at 0.
6. **Reset mid-burst:** pulse `rst` during owner 2's beat 2 with `req[0]`,`req[2]`=1 -> next cycle all outputs at reset values. The first post-reset burst goes to requester 0.
